velocity_cell_streamer: RTL and testbench
=========================================

VELOCITY_CELL_STREAMER -- requirements
Module: velocity_cell_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 96, is the velocity word {vz, vy, vx}, 32 bits each, vx in the LSBs.
REQ-002 Parameter ADDR_WIDTH, default 8, is the cell memory address width.
REQ-003 Parameter PARTICLE_NUM, default 220, is the cell memory depth in words; address 0 holds the particle count.
REQ-004 Single clock domain: one clock; reset is synchronous and active-low.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse that begins a cell pass; ignored while busy=1.
REQ-008 busy  out  1  high from the cycle after an accepted start until the done pulse.
REQ-009 done  out  1  one-cycle pulse when the last particle has been accepted downstream.
REQ-010 particle_count  out  ADDR_WIDTH  count latched from address 0 (after clamping).
REQ-011 mem_address  out  ADDR_WIDTH  cell memory address.
REQ-012 mem_rden, mem_wren  out  1 each  cell memory read and write enables; never both high in one cycle.
REQ-013 mem_data  out  DATA_WIDTH  cell memory write data.
REQ-014 mem_q  in  DATA_WIDTH  cell memory read data, valid 1 cycle after mem_rden.
REQ-015 out_valid, out_ready  out/in  1  downstream stream handshake; transfer when both high.
REQ-016 out_data  out  DATA_WIDTH; out_particle_id  out  ADDR_WIDTH  velocity and its address (1..N).
REQ-017 wb_valid, wb_ready  in/out  1  write-back handshake from motion update.
REQ-018 wb_particle_id  in  ADDR_WIDTH; wb_data  in  DATA_WIDTH  write-back target and value.
REQ-019 wb_error  out  1  sticky flag: a write-back to address 0 was attempted; cleared by start or reset.

Function
REQ-020 FSM states: IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN; reset state is IDLE.
REQ-021 IDLE->RD_CNT on start; RD_CNT drives mem_address=0, mem_rden=1 for one cycle, then goes to WAIT_CNT.
REQ-022 WAIT_CNT latches count = mem_q[ADDR_WIDTH-1:0], clamped to PARTICLE_NUM-1; goes to DRAIN if count=0, else to STREAM.
REQ-023 STREAM issues reads to addresses 1..count in ascending order through a 2-entry output FIFO.
REQ-024 A read is issued only when FIFO occupancy plus reads in flight is less than 2; no data is ever dropped or duplicated.
REQ-025 After the read of address count is issued, go to DRAIN; DRAIN->IDLE with done=1 when the FIFO is empty and no read is in flight.
REQ-026 out_valid = FIFO not empty; out_data/out_particle_id = FIFO head, held stable while out_valid=1 and out_ready=0.
REQ-027 Minimum latency: first out_valid 4 cycles after the start pulse; sustained throughput 1 particle/cycle when out_ready=1.
REQ-028 Write-back is accepted in any state except RD_CNT; a write-back takes the memory port, and a STREAM read stalls that cycle.
REQ-029 On an accepted write-back with wb_particle_id≠0: mem_wren=1, mem_address=wb_particle_id, mem_data=wb_data in that cycle.
REQ-030 wb_particle_id=0 is handshaken (wb_ready=1) but not written; wb_error is set.
REQ-031 A write-back to an address not yet streamed in the current pass is written; the later read returns the new value (no forwarding needed).
REQ-032 start during busy has no effect; start in the same cycle as done is ignored.

Reset
REQ-033 With rst_n=0 at a clock edge: state=IDLE, FIFO empty, in-flight cleared, busy=0, done=0, out_valid=0, mem_rden=0, mem_wren=0, wb_error=0, particle_count=0, mem_address=0.
REQ-034 Reset mid-pass aborts the pass with no done pulse; in-flight read data arriving after reset is discarded.

Structure
REQ-035 The FSM state encoding and the DATA_WIDTH/ADDR_WIDTH defaults SHALL live in the shared define file, next to the existing cell-memory widths.
REQ-036 The 2-entry output FIFO SHALL be a sub-module, stream_skid_fifo (parameterised width, count output).

Verification
REQ-037 Count word=5, out_ready=1 -> ids 1..5 on 5 consecutive cycles starting 4 cycles after start, then a done pulse, busy low.
REQ-038 Count=0 -> no out_valid, done pulse 3 cycles after start.
REQ-039 Count=8, out_ready toggled 1/0 -> all 8 ids in order, no repeats, data stable during stalls.
REQ-040 Write-back (id=3, 0x…AA) every cycle during a count=6 pass -> mem_rden and mem_wren never both high, stream completes, and re-reading id 3 returns 0x…AA.
REQ-041 Write-back id=0 -> no mem_wren, wb_error=1 until the next start.
REQ-042 rst_n low for 1 cycle at the 2nd output beat of a count=10 pass -> all outputs at reset values, no done; a new start runs a clean pass.

Source files
------------

// File: rtl/velocity_cell_streamer_pkg.sv
// Shared cell-memory widths and streamer FSM encoding.
// Imported by the streamer, its bus interface and the bench.
package velocity_cell_streamer_pkg;

  localparam int unsigned CELL_DATA_WIDTH   = 96;
  localparam int unsigned CELL_ADDR_WIDTH   = 8;
  localparam int unsigned CELL_PARTICLE_NUM = 220;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CNT,
    ST_WAIT_CNT,
    ST_STREAM,
    ST_DRAIN
  } stream_state_t;

endpackage

// File: rtl/velocity_cell_streamer_if.sv
// Cell-memory port, downstream velocity stream and write-back channel.
// master = streamer side, slave = memory / consumer / motion-update side.
interface velocity_cell_streamer_if
  import velocity_cell_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CELL_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = CELL_ADDR_WIDTH
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_q;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_particle_id;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_particle_id;
  logic [DATA_WIDTH-1:0] wb_data;

  modport master (
    output mem_address, mem_rden, mem_wren, mem_data,
    input  mem_q,
    output out_valid, out_data, out_particle_id,
    input  out_ready,
    input  wb_valid, wb_particle_id, wb_data,
    output wb_ready
  );

  modport slave (
    input  mem_address, mem_rden, mem_wren, mem_data,
    output mem_q,
    input  out_valid, out_data, out_particle_id,
    output out_ready,
    output wb_valid, wb_particle_id, wb_data,
    input  wb_ready
  );
endinterface

// File: rtl/stream_skid_fifo.sv
// Two-entry output FIFO; head is presented whenever count is non-zero.
// The caller guarantees no push into a full FIFO unless it pops in the same cycle.
module stream_skid_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] slot [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             pop;

  assign valid = (count != 2'd0);
  assign head  = slot[rd_ptr];
  assign pop   = valid && pop_ready;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= push_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/velocity_cell_streamer.sv
// Streams the velocity words of one cell (addresses 1..N, N read from address 0)
// to a downstream consumer while sharing the memory port with motion-update write-backs.
module velocity_cell_streamer
  import velocity_cell_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = CELL_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = CELL_ADDR_WIDTH,
  parameter int unsigned PARTICLE_NUM = CELL_PARTICLE_NUM
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  wb_error,
  velocity_cell_streamer_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  stream_state_t          state;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [ADDR_WIDTH-1:0]  inflight_id;
  logic                   inflight;
  logic                   last_wb;
  logic [ADDR_WIDTH-1:0]  cnt_raw;
  logic [ADDR_WIDTH-1:0]  cnt_clamped;

  logic                   fifo_valid;
  logic [1:0]             fifo_count;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_head;

  logic pop, read_ok, wb_acc, wb_write, rd_issue, start_acc;

  assign cnt_raw     = bus.mem_q[ADDR_WIDTH-1:0];
  assign cnt_clamped = (cnt_raw > MAX_COUNT) ? MAX_COUNT : cnt_raw;

  // A slot is free when occupancy after this cycle's pop plus the read whose
  // data is on mem_q right now leaves room; this keeps 1 beat/cycle with 2 entries.
  // After a granted write-back, an eligible read wins the port so a continuous
  // write-back stream cannot starve the pass.
  always_comb begin
    pop       = fifo_valid && bus.out_ready;
    read_ok   = (state == ST_STREAM) &&
                (({1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight}) < 3'd2);
    bus.wb_ready = (state != ST_RD_CNT) && !(read_ok && last_wb);
    wb_acc    = bus.wb_valid && bus.wb_ready;
    wb_write  = wb_acc && (bus.wb_particle_id != '0);
    rd_issue  = read_ok && !wb_acc;
    start_acc = start && (state == ST_IDLE) && !done;

    bus.mem_wren    = wb_write;
    bus.mem_rden    = rd_issue || (state == ST_RD_CNT);
    bus.mem_data    = wb_write ? bus.wb_data : '0;
    bus.mem_address = '0;
    if (wb_write)      bus.mem_address = bus.wb_particle_id;
    else if (rd_issue) bus.mem_address = rd_addr;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      particle_count <= '0;
      rd_addr        <= '0;
      inflight       <= 1'b0;
      inflight_id    <= '0;
      last_wb        <= 1'b0;
      wb_error       <= 1'b0;
    end else begin
      done        <= 1'b0;
      inflight    <= rd_issue;
      inflight_id <= rd_addr;
      last_wb     <= wb_acc;
      if (start_acc) wb_error <= 1'b0;
      if (wb_acc && (bus.wb_particle_id == '0)) wb_error <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            state <= ST_RD_CNT;
            busy  <= 1'b1;
          end
        end
        ST_RD_CNT: state <= ST_WAIT_CNT;
        ST_WAIT_CNT: begin
          particle_count <= cnt_clamped;
          rd_addr        <= ADDR_WIDTH'(1);
          state          <= (cnt_clamped == '0) ? ST_DRAIN : ST_STREAM;
        end
        ST_STREAM: begin
          if (rd_issue) begin
            if (rd_addr == particle_count) state <= ST_DRAIN;
            else rd_addr <= rd_addr + ADDR_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (!inflight && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  stream_skid_fifo #(
    .WIDTH(ADDR_WIDTH + DATA_WIDTH)
  ) u_fifo (
    .clock     (clock),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data ({inflight_id, bus.mem_q}),
    .pop_ready (bus.out_ready),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.out_valid       = fifo_valid;
  assign bus.out_data        = fifo_head[DATA_WIDTH-1:0];
  assign bus.out_particle_id = fifo_head[DATA_WIDTH +: ADDR_WIDTH];
endmodule

// File: tb/tb_velocity_cell_streamer.sv
// Directed bench: behavioural cell memory, scoreboard of expected beats and a
// monitor that checks every downstream transfer, stall hold and port exclusivity.
module tb_velocity_cell_streamer;
  import velocity_cell_streamer_pkg::*;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam logic [DW-1:0] WB_VAL = {3{32'hAAAA_AAAA}};

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, wb_error;
  logic [AW-1:0] particle_count;

  velocity_cell_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  velocity_cell_streamer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(220)
  ) dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .particle_count (particle_count),
    .wb_error       (wb_error),
    .bus            (bus)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [256];
  logic          tb_wr = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [DW-1:0] tb_data = '0;

  always @(posedge clock) begin
    if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
    else if (tb_wr)   mem[tb_addr] <= tb_data;
    if (bus.mem_rden) bus.mem_q <= mem[bus.mem_address];
  end

  typedef struct packed {
    logic [AW-1:0] id;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         sb[$];
  logic [DW-1:0] exp_mem [16];
  int            n_vec = 0;
  int            n_err = 0;

  function automatic logic [DW-1:0] vel(input int i);
    return {32'(32'h3000_0000 + i), 32'(32'h2000_0000 + i), 32'(32'h1000_0000 + i)};
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic  stall;
    beat_t held;
    beat_t e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        stall = 1'b0;
        continue;
      end
      if (bus.mem_rden || bus.mem_wren)
        check_bit("port_excl", bus.mem_rden & bus.mem_wren, 1'b0);
      if (stall) begin
        check_bit("stall_valid", bus.out_valid, 1'b1);
        check_vec("stall_hold", 128'({bus.out_particle_id, bus.out_data}), 128'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got id %0d expected no beat", bus.out_particle_id);
        end else begin
          e = sb.pop_front();
          check_vec("beat_id", 128'(bus.out_particle_id), 128'(e.id));
          check_vec("beat_data", 128'(bus.out_data), 128'(e.data));
        end
      end
      stall     = bus.out_valid && !bus.out_ready;
      held.id   = bus.out_particle_id;
      held.data = bus.out_data;
    end
  endtask

  task automatic poke(input int a, input logic [DW-1:0] d);
    tb_wr   = 1'b1;
    tb_addr = AW'(a);
    tb_data = d;
    @(posedge clock); #1;
    tb_wr   = 1'b0;
  endtask

  task automatic push_expected(input int n);
    beat_t b;
    for (int i = 1; i <= n; i++) begin
      b.id   = AW'(i);
      b.data = exp_mem[i];
      sb.push_back(b);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that samples start.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit, input bit toggle);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clock); #1;
      if (toggle) bus.out_ready = ~bus.out_ready;
    end
    check_bit(name, seen, 1'b1);
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    check_vec({name, "_sb_empty"}, 128'(sb.size()), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    bus.out_ready      = 1'b1;
    bus.wb_valid       = 1'b0;
    bus.wb_particle_id = '0;
    bus.wb_data        = '0;
    fork
      monitor();
    join_none

    // Reset and memory preload
    @(posedge clock); #1;
    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = vel(i);
      if (i == 0) poke(0, 96'd5);
      else        poke(i, vel(i));
    end
    @(negedge clock);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check_bit("rst_rden", bus.mem_rden, 1'b0);
    check_bit("rst_wren", bus.mem_wren, 1'b0);
    check_bit("rst_wb_error", wb_error, 1'b0);
    check_vec("rst_count", 128'(particle_count), 128'(0));
    check_vec("rst_addr", 128'(bus.mem_address), 128'(0));
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(posedge clock); #1;

    // count=5, out_ready=1: beats in cycles 4..8, done in cycle 9
    push_expected(5);
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      check_bit("c5_valid", bus.out_valid, (k >= 4 && k <= 8));
      check_bit("c5_done", done, (k == 9));
      check_bit("c5_busy", busy, (k <= 8));
      if (k == 2) check_vec("c5_count", 128'(particle_count), 128'(5));
      @(posedge clock); #1;
    end
    check_vec("c5_sb_empty", 128'(sb.size()), 128'(0));

    // write-back to id 0 while idle
    bus.wb_valid = 1'b1; bus.wb_particle_id = '0; bus.wb_data = WB_VAL;
    @(negedge clock);
    check_bit("wb0_ready", bus.wb_ready, 1'b1);
    check_bit("wb0_no_wren", bus.mem_wren, 1'b0);
    @(posedge clock); #1;
    bus.wb_valid = 1'b0;
    @(negedge clock);
    check_bit("wb0_err_set", wb_error, 1'b1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_bit("wb0_err_sticky", wb_error, 1'b1);
    @(posedge clock); #1;

    // count=0: no beats, done 3 cycles after start, start clears wb_error
    poke(0, 96'd0);
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check_bit("c0_valid", bus.out_valid, 1'b0);
      check_bit("c0_done", done, (k == 3));
      check_bit("c0_busy", busy, (k <= 2));
      if (k == 0) check_bit("c0_err_clr", wb_error, 1'b0);
      @(posedge clock); #1;
    end

    // count=8 with out_ready toggling
    poke(0, 96'd8);
    push_expected(8);
    pulse_start();
    wait_done("c8_done", 80, 1'b1);

    // count=6 with a write-back to id 3 offered every cycle
    poke(0, 96'd6);
    exp_mem[3] = WB_VAL;
    push_expected(6);
    bus.wb_valid = 1'b1; bus.wb_particle_id = AW'(3); bus.wb_data = WB_VAL;
    pulse_start();
    wait_done("wb_done", 100, 1'b0);
    bus.wb_valid = 1'b0;
    @(posedge clock); #1;
    push_expected(6);
    pulse_start();
    wait_done("wb_reread_done", 40, 1'b0);

    // count=10, reset during the second beat, then a clean pass
    poke(0, 96'd10);
    push_expected(10);
    pulse_start();
    repeat (5) begin
      @(posedge clock); #1;
    end
    rst_n = 1'b0;
    @(posedge clock); #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clock);
    check_bit("mid_rst_busy", busy, 1'b0);
    check_bit("mid_rst_valid", bus.out_valid, 1'b0);
    check_bit("mid_rst_rden", bus.mem_rden, 1'b0);
    check_vec("mid_rst_count", 128'(particle_count), 128'(0));
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      @(negedge clock);
      check_bit("mid_rst_no_done", done, 1'b0);
      check_bit("mid_rst_no_valid", bus.out_valid, 1'b0);
    end
    @(posedge clock); #1;
    push_expected(10);
    pulse_start();
    wait_done("post_rst_done", 40, 1'b0);
    check_vec("post_rst_count", 128'(particle_count), 128'(10));
    check_bit("post_rst_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
